// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_block #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     tx_start,
  input  logic [NUM_DATA_BITS-1:0] tx_data,
  output logic                     serial_out,
  output logic                     tx_busy,
  output logic                     tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  IDX_LAST   = 4'(NUM_DATA_BITS);

  state_t                   state_r;
  logic [15:0]              timer_r;
  logic [3:0]               idx_r;
  logic [NUM_DATA_BITS-1:0] shift_r;
  logic                     accept_s;
  logic                     bit_tick_s;

`ifdef UART_TX_PARITY_EN
  logic parity_r;

  function automatic logic even_parity(input logic [NUM_DATA_BITS-1:0] d);
    logic p;
    p = 1'b0;
    for (int i = 0; i < NUM_DATA_BITS; i++) begin
      p = p ^ d[i];
    end
    return p;
  endfunction
`endif

  // Accept decode and end-of-bit tick
  always_comb begin
    accept_s   = 1'b0;
    bit_tick_s = 1'b0;
    if (state_r == IDLE) begin
      accept_s = tx_start;
    end else begin
      bit_tick_s = (timer_r == TIMER_LAST);
    end
  end

  // Bit-period timer: restarts on accept so every bit is exactly CLKS_PER_BIT long
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer_r <= 16'd0;
    end else if (accept_s || bit_tick_s || (state_r == IDLE)) begin
      timer_r <= 16'd0;
    end else begin
      timer_r <= timer_r + 16'd1;
    end
  end

  // Data-bit index: 1..NUM_DATA_BITS while in DATA, cleared on accept
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_r <= 4'd0;
    end else if (accept_s) begin
      idx_r <= 4'd0;
    end else if (bit_tick_s && (state_r == START)) begin
      idx_r <= 4'd1;
    end else if (bit_tick_s && (state_r == DATA) && (idx_r != IDX_LAST)) begin
      idx_r <= idx_r + 4'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            shift_r    <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_r   <= even_parity(tx_data);
`endif
            state_r    <= START;
            serial_out <= 1'b0;
            tx_busy    <= 1'b1;
          end else begin
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
          end
        end
        START: begin
          if (bit_tick_s) begin
            state_r    <= DATA;
            serial_out <= shift_r[0];
          end
        end
        DATA: begin
          if (bit_tick_s) begin
            if (idx_r == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_r    <= PARITY;
              serial_out <= parity_r;
`else
              state_r    <= STOP;
              serial_out <= 1'b1;
`endif
            end else begin
              // Next bit is read before the shift lands
              shift_r    <= shift_r >> 1;
              serial_out <= shift_r[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick_s) begin
            state_r    <= STOP;
            serial_out <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_tick_s) begin
            state_r    <= IDLE;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          serial_out <= 1'b1;
          tx_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// Scoreboard bench for uart_tx_block; the monitor checks every line cycle of each frame.
module tb_uart_tx_block;
`ifdef UART_TX_PARITY_EN
  localparam int C = 4;
  localparam int P = 1;
`else
  localparam int C = 10;
  localparam int P = 0;
`endif
  localparam int N = 8;
  localparam int L = (2 + N + P) * C;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       serial_out;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [7:0] exp_q[$];
  logic       exp_bits[0:11];
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;

  uart_tx_block #(.CLKS_PER_BIT(C), .NUM_DATA_BITS(N)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
    .serial_out(serial_out), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Monitor: pop the expected byte when a frame starts, then check each cycle
  always @(negedge clk) begin
    logic [7:0] d;
    if (!n_rst) begin
      mon_active = 1'b0;
      exp_q.delete();
    end else begin
      if (!mon_active && tx_busy) begin
        if (exp_q.size() == 0) begin
          check_val("sb_underflow", 32'(0), 32'(1));
        end else begin
          d = exp_q.pop_front();
          exp_bits[0] = 1'b0;
          for (int i = 0; i < N; i++) exp_bits[1 + i] = d[i];
          if (P == 1) exp_bits[N + 1] = ^d;
          exp_bits[N + 1 + P] = 1'b1;
          mon_active = 1'b1;
          mon_cnt = 0;
        end
      end
      if (mon_active) begin
        if (mon_cnt < L) begin
          check_val("line", 32'(serial_out), 32'(exp_bits[mon_cnt / C]));
          check_val("busy", 32'(tx_busy), 32'(1));
          check_val("done_early", 32'(tx_done), 32'(0));
          mon_cnt++;
        end else begin
          check_val("done", 32'(tx_done), 32'(1));
          check_val("busy_end", 32'(tx_busy), 32'(0));
          check_val("line_end", 32'(serial_out), 32'(1));
          done_cnt++;
          mon_active = 1'b0;
        end
      end else if (tx_done) begin
        check_val("stray_done", 32'(tx_done), 32'(0));
      end
    end
  end

  task automatic send(input logic [7:0] d, output int acc);
    @(negedge clk);
    tx_data = d;
    tx_start = 1'b1;
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(output int dc);
    bit found;
    found = 1'b0;
    dc = -1;
    for (int i = 0; i < L + 20; i++) begin
      @(negedge clk);
      if (tx_done) begin
        dc = cyc;
        found = 1'b1;
        break;
      end
    end
    if (!found) check_val("timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dc, acc2, d0;
    repeat (3) @(negedge clk);
    check_val("rst_line", 32'(serial_out), 32'(1));
    check_val("rst_busy", 32'(tx_busy), 32'(0));
    check_val("rst_done", 32'(tx_done), 32'(0));
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame
    send(8'hA5, acc);
    wait_done(dc);
    check_val("latency_a5", 32'(dc - acc), 32'(L));
    repeat (3) @(negedge clk);

    // Start request while busy must be ignored
    d0 = done_cnt;
    send(8'h3C, acc);
    repeat (30) @(negedge clk);
    tx_data = 8'hFF;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done(dc);
    check_val("latency_3c", 32'(dc - acc), 32'(L));
    repeat (5) @(negedge clk);
    check_val("ignored_done_cnt", 32'(done_cnt - d0), 32'(1));

    // Back-to-back with tx_start held through the done cycle
    send(8'h01, acc);
    tx_data = 8'h80;
    tx_start = 1'b1;
    wait_done(dc);
    check_val("latency_01", 32'(dc - acc), 32'(L));
    exp_q.push_back(8'h80);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    acc2 = cyc;
    check_val("b2b_gap", 32'(acc2 - dc), 32'(1));
    @(negedge clk);
    check_val("b2b_start_line", 32'(serial_out), 32'(0));
    wait_done(dc);
    check_val("latency_80", 32'(dc - acc2), 32'(L));
    repeat (3) @(negedge clk);

    // Reset during the data bits of an all-zero frame
    send(8'h00, acc);
    repeat (35) @(negedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check_val("mid_rst_line", 32'(serial_out), 32'(1));
    check_val("mid_rst_busy", 32'(tx_busy), 32'(0));
    check_val("mid_rst_done", 32'(tx_done), 32'(0));
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("post_rst_idle", 32'(serial_out), 32'(1));
    send(8'h55, acc);
    wait_done(dc);
    check_val("latency_55", 32'(dc - acc), 32'(L));
    repeat (2) @(negedge clk);

    // Parity-sensitive pattern, then a few random bytes
    send(8'h07, acc);
    wait_done(dc);
    check_val("latency_07", 32'(dc - acc), 32'(L));
    for (int k = 0; k < 4; k++) begin
      send(8'($urandom_range(0, 255)), acc);
      wait_done(dc);
      check_val("latency_rand", 32'(dc - acc), 32'(L));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_val("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_block.md
# uart_tx_block

Serial transmitter that frames a parallel byte as asynchronous UART (start bit, LSB-first data, optional even parity, one stop bit) on a single line. It is the transmit-side counterpart of the team's UART receive path and uses the team's flex counters for bit-period timing and bit indexing. Upstream logic hands it one byte at a time with a start/busy handshake. The block drives the serial line directly.

## Interface
- CLKS_PER_BIT, default 10: clock cycles per serial bit; legal range 1..65535.
- NUM_DATA_BITS, default 8: data bits per frame; legal range 5..8.
- clk  in  1  system clock, all state updates on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- tx_start  in  1  request to send tx_data; sampled only when tx_busy=0.
- tx_data  in  NUM_DATA_BITS  byte to send; captured on the accepting edge.
- serial_out  out  1  UART line; idle high.
- tx_busy  out  1  high while a frame is in progress.
- tx_done  out  1  single-cycle pulse at frame completion.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: serial_out=1, tx_busy=0. On an edge with tx_start=1, the block captures tx_data into a shift register and goes to START.
- START: serial_out=0 for CLKS_PER_BIT cycles, then goes to DATA.
- DATA: drives bit 0 first. Each bit is held CLKS_PER_BIT cycles. After NUM_DATA_BITS bits, goes to PARITY, or to STOP if parity is compiled out.
- PARITY: drives the XOR of all captured data bits (even parity) for CLKS_PER_BIT cycles, then goes to STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles, then goes to IDLE with a tx_done pulse.
- Bit timer: counts 1..CLKS_PER_BIT and rolls over to advance to the next bit. It clears on accept so that every bit has an exact period.
- Bit index counter: counts data bits 1..NUM_DATA_BITS. It clears on entry to START.
- tx_start while tx_busy=1 is ignored. It is neither queued nor able to corrupt the frame.
- tx_data changes after capture have no effect on the frame in flight.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: serial_out=1, tx_busy=0, tx_done=0, state IDLE, counters 0.
- Reset mid-frame: outputs go to their reset values immediately (asynchronously). The partial frame is abandoned.

## Timing
- Let k be the edge that accepts tx_start. C=CLKS_PER_BIT, N=NUM_DATA_BITS, P=1 if parity is compiled in, else 0.
- After edge k: serial_out=0 and tx_busy=1.
- After edge k+(1+i)·C: serial_out=data[i], for i=0..N-1.
- After edge k+(1+N)·C: parity bit if P=1. Otherwise stop bit (serial_out=1).
- After edge k+(2+N+P)·C: tx_busy=0 and tx_done=1 for exactly one cycle; serial_out stays 1.
- Frame length is (2+N+P)·C cycles. With the defaults and no parity, this is 100 cycles.
- Back-to-back: tx_start=1 during the tx_done cycle is accepted on the next edge. The next start bit then follows the stop bit with zero idle cycles.
- C=1: every bit lasts one cycle and there is no extra bubble between bits.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state exists and one even-parity bit follows the data bits. Frame length is (3+N)·C cycles.
- Undefined: no PARITY state and no parity logic. Frame length is (2+N)·C cycles.
- Port list is identical in both builds.

## Test plan
- Reset: assert n_rst=0 mid-simulation → serial_out=1, tx_busy=0, tx_done=0 immediately, with no clock edge required.
- Single frame, defaults, no parity: tx_data=0xA5, pulse tx_start.
  - serial_out must be 0, then 1,0,1,0,0,1,0,1, then 1.
  - Each level must last 10 cycles.
  - tx_done must pulse once, 100 cycles after the accept edge.
- Ignored start: assert tx_start with tx_data=0xFF at cycle 30 of a 0x3C frame → the waveform remains exactly 0x3C and only one tx_done occurs.
- Back-to-back: 0x01 then 0x80, with tx_start held high through the tx_done cycle → two contiguous 100-cycle frames and no idle gap between them.
- Mid-frame reset: pulse n_rst low during the data bits, then send 0x55 → the line idles high and the new frame is complete and correct.
- Parity build (UART_TX_PARITY_EN, C=4): tx_data=0x07 → the parity bit is 1, the frame is 44 cycles, and tx_done pulses at cycle 44.
